ws2812_stream_loader: RTL and testbench

//  Upstream feeder for the ws2812 driver: accepts a byte stream (from the SPI/UART

---
 rtl/ws2812_pkg.sv | 16 +
 rtl/ws2812_stream_loader.sv | 105 ++++++++++
 tb/tb_ws2812_stream_loader.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812_pkg.sv
// Shared definitions for the ws2812 feeder path: LED index width, byte-slot
// bit positions inside a packed colour word, and the loader state encoding.
package ws2812_pkg;

   localparam int LED_W    = 8;
   localparam int SLOT_HI  = 16;
   localparam int SLOT_MID = 8;
   localparam int SLOT_LO  = 0;

   typedef enum logic [1:0] {
      S_COLLECT = 2'd0,
      S_EMIT    = 2'd1,
      S_FULL    = 2'd2
   } state_t;

endpackage

// File: rtl/ws2812_stream_loader.sv
// Packs an incoming byte stream into 24-bit colour words, three bytes per LED,
// and issues one single-cycle write per LED to the ws2812 driver port.
module ws2812_stream_loader
   import ws2812_pkg::*;
#(
   parameter int NUM_LEDS  = 8,
   parameter bit AUTO_WRAP = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             frame_start,
   input  logic [7:0]       byte_data,
   input  logic             byte_valid,
   output logic             byte_ready,
   output logic [23:0]      rgb_data,
   output logic [LED_W-1:0] led_num,
   output logic             write,
   output logic             frame_done,
   output logic             overflow
);

   localparam logic [LED_W-1:0] LAST_LED = LED_W'(NUM_LEDS - 1);

   // valid/ready: a byte moves on a rising edge where byte_valid && byte_ready;
   // the source must hold byte_data while valid is high and ready is low.
   state_t           state, state_nx;
   logic [1:0]       byte_cnt, byte_cnt_nx;
   logic [23:0]      rgb_nx;
   logic [LED_W-1:0] led_nx;
   logic             overflow_nx;
   logic             accept;

   assign byte_ready = (state == S_COLLECT || state == S_FULL) && !frame_start && !reset;
   assign accept     = byte_valid && byte_ready;
   assign write      = (state == S_EMIT);
   assign frame_done = write && (led_num == LAST_LED);

   always_comb begin
      state_nx    = state;
      byte_cnt_nx = byte_cnt;
      rgb_nx      = rgb_data;
      led_nx      = led_num;
      overflow_nx = overflow;

      case (state)
         S_COLLECT: begin
            if (accept) begin
               case (byte_cnt)
                  2'd0:    rgb_nx[SLOT_HI  +: 8] = byte_data;
                  2'd1:    rgb_nx[SLOT_MID +: 8] = byte_data;
                  default: rgb_nx[SLOT_LO  +: 8] = byte_data;
               endcase
               if (byte_cnt == 2'd2) begin
                  byte_cnt_nx = 2'd0;
                  state_nx    = S_EMIT;
               end else begin
                  byte_cnt_nx = byte_cnt + 2'd1;
               end
            end
         end
         S_EMIT: begin
            if (led_num == LAST_LED) begin
               if (AUTO_WRAP) begin
                  led_nx   = '0;
                  state_nx = S_COLLECT;
               end else begin
                  state_nx = S_FULL;
               end
            end else begin
               led_nx   = led_num + LED_W'(1);
               state_nx = S_COLLECT;
            end
         end
         S_FULL: begin
            if (accept) overflow_nx = 1'b1;
         end
         default: state_nx = S_COLLECT;
      endcase

      // A frame restart overrides everything, including the post-emit LED advance.
      if (frame_start) begin
         state_nx    = S_COLLECT;
         byte_cnt_nx = 2'd0;
         led_nx      = '0;
         overflow_nx = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_COLLECT;
         byte_cnt <= 2'd0;
         rgb_data <= '0;
         led_num  <= '0;
         overflow <= 1'b0;
      end else begin
         state    <= state_nx;
         byte_cnt <= byte_cnt_nx;
         rgb_data <= rgb_nx;
         led_num  <= led_nx;
         overflow <= overflow_nx;
      end
   end

endmodule

// File: tb/tb_ws2812_stream_loader.sv
// Bench for ws2812_stream_loader: three configurations share one stimulus bus,
// a reference model fills an expected queue and a monitor checks every write.
module tb_ws2812_stream_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        frame_start = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_valid = 1'b0;
   int          sel = 0;

   logic        ready_a [3];
   logic [23:0] rgb_a   [3];
   logic [7:0]  led_a   [3];
   logic        write_a [3];
   logic        fd_a    [3];
   logic        ovf_a   [3];

   logic        ready, write, fd, ovf;
   logic [23:0] rgb;
   logic [7:0]  led;

   assign ready = ready_a[sel];
   assign rgb   = rgb_a[sel];
   assign led   = led_a[sel];
   assign write = write_a[sel];
   assign fd    = fd_a[sel];
   assign ovf   = ovf_a[sel];

   always #5 clk = ~clk;

   ws2812_stream_loader #(.NUM_LEDS(8), .AUTO_WRAP(1'b0)) dut_n8 (
      .clk(clk), .reset(reset), .frame_start(frame_start), .byte_data(byte_data),
      .byte_valid(byte_valid), .byte_ready(ready_a[0]), .rgb_data(rgb_a[0]),
      .led_num(led_a[0]), .write(write_a[0]), .frame_done(fd_a[0]), .overflow(ovf_a[0]));

   ws2812_stream_loader #(.NUM_LEDS(4), .AUTO_WRAP(1'b0)) dut_n4 (
      .clk(clk), .reset(reset), .frame_start(frame_start), .byte_data(byte_data),
      .byte_valid(byte_valid), .byte_ready(ready_a[1]), .rgb_data(rgb_a[1]),
      .led_num(led_a[1]), .write(write_a[1]), .frame_done(fd_a[1]), .overflow(ovf_a[1]));

   ws2812_stream_loader #(.NUM_LEDS(4), .AUTO_WRAP(1'b1)) dut_n4_wrap (
      .clk(clk), .reset(reset), .frame_start(frame_start), .byte_data(byte_data),
      .byte_valid(byte_valid), .byte_ready(ready_a[2]), .rgb_data(rgb_a[2]),
      .led_num(led_a[2]), .write(write_a[2]), .frame_done(fd_a[2]), .overflow(ovf_a[2]));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model of the loader, advanced on every accepted byte.
   int          m_num = 8;
   bit          m_wrap = 1'b0;
   int          m_cnt = 0;
   int          m_led = 0;
   bit          m_full = 1'b0;
   bit          m_ovf = 1'b0;
   logic [23:0] m_rgb = '0;

   logic [32:0] exp_q[$];   // {frame_done, led_num, rgb_data}
   bit          pending = 1'b0;
   bit          chk_rdy = 1'b0;
   int          wr_cnt = 0;
   int          fd_cnt = 0;

   task automatic model_clear();
      m_cnt  = 0;
      m_led  = 0;
      m_full = 1'b0;
      m_ovf  = 1'b0;
   endtask

   task automatic model_accept(input logic [7:0] b);
      if (m_full) begin
         m_ovf = 1'b1;
      end else begin
         if (m_cnt == 0)      m_rgb[23:16] = b;
         else if (m_cnt == 1) m_rgb[15:8]  = b;
         else                 m_rgb[7:0]   = b;
         if (m_cnt == 2) begin
            exp_q.push_back({(m_led == m_num - 1), 8'(m_led), m_rgb});
            pending = 1'b1;
            m_cnt = 0;
            if (m_led == m_num - 1) begin
               if (m_wrap) m_led = 0;
               else        m_full = 1'b1;
            end else begin
               m_led++;
            end
         end else begin
            m_cnt++;
         end
      end
   endtask

   // Monitor: samples mid-low-phase, well away from the rising edge.
   always @(negedge clk) begin
      logic [32:0] e;
      #2;
      if (pending) begin
         check("write_latency", write, 1);
         pending = 1'b0;
      end
      if (write) begin
         wr_cnt++;
         if (fd) fd_cnt++;
         check("ready_in_write", ready, 0);
         if (exp_q.size() == 0) begin
            check("unexpected_write", write, 0);
         end else begin
            e = exp_q.pop_front();
            check("rgb_data", rgb, e[23:0]);
            check("led_num", led, e[31:24]);
            check("frame_done", fd, e[32]);
         end
      end else begin
         check("frame_done_no_write", fd, 0);
      end
      if (chk_rdy) check("ready_vs_write", ready, !write);
   end

   task automatic send_byte(input logic [7:0] b);
      bit done = 1'b0;
      bit acc;
      byte_data  = b;
      byte_valid = 1'b1;
      for (int t = 0; t < 16 && !done; t++) begin
         #1;
         acc = ready;
         @(posedge clk);
         if (acc) begin
            model_accept(b);
            done = 1'b1;
         end
         @(negedge clk);
      end
      if (!done) check("accept_timeout", 0, 1);
   endtask

   task automatic idle(input int n);
      byte_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_frame_start(input bit with_byte);
      frame_start = 1'b1;
      byte_valid  = with_byte;
      byte_data   = 8'hEE;
      #1;
      check("ready_during_frame_start", ready, 0);
      @(posedge clk);
      model_clear();
      @(negedge clk);
      frame_start = 1'b0;
      byte_valid  = 1'b0;
   endtask

   task automatic apply_reset(input int s);
      reset      = 1'b1;
      byte_valid = 1'b0;
      sel        = s;
      m_num      = (s == 0) ? 8 : 4;
      m_wrap     = (s == 2);
      #1;
      check("rst_rgb", rgb, 0);
      check("rst_led", led, 0);
      check("rst_write", write, 0);
      check("rst_overflow", ovf, 0);
      check("rst_ready", ready, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_clear();
      check("queue_empty_at_reset", exp_q.size(), 0);
      exp_q.delete();
      wr_cnt = 0;
      fd_cnt = 0;
      #1;
      check("ready_after_reset", ready, 1);
      @(negedge clk);
   endtask

   task automatic send_n(input int n);
      for (int i = 0; i < n; i++) send_byte(8'($urandom_range(0, 255)));
      idle(3);
   endtask

   initial begin
      @(negedge clk);
      apply_reset(0);

      // Back-to-back bytes with valid held high.
      chk_rdy = 1'b1;
      send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
      send_byte(8'h40); send_byte(8'h50); send_byte(8'h60);
      idle(3);
      chk_rdy = 1'b0;
      check("t1_writes", wr_cnt, 2);

      // Random gaps over a full frame of 8 LEDs.
      pulse_frame_start(1'b0);
      wr_cnt = 0;
      fd_cnt = 0;
      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
         send_byte(8'($urandom_range(0, 255)));
      end
      idle(4);
      check("t2_writes", wr_cnt, 8);
      check("t2_frame_done_count", fd_cnt, 1);
      check("t2_overflow", ovf, 0);

      // Overflow without auto-wrap.
      apply_reset(1);
      send_n(12);
      check("t3_no_overflow_yet", ovf, 0);
      send_n(3);
      check("t3_writes", wr_cnt, 4);
      check("t3_overflow", ovf, 1);
      check("t3_model_overflow", ovf, m_ovf);
      pulse_frame_start(1'b0);
      check("t3_overflow_cleared", ovf, 0);
      send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
      idle(3);
      check("t3_writes_after_restart", wr_cnt, 5);

      // Auto-wrap continues at LED 0.
      apply_reset(2);
      send_n(15);
      check("t4_writes", wr_cnt, 5);
      check("t4_overflow", ovf, 0);
      check("t4_frame_done_count", fd_cnt, 1);

      // Partial triplet discarded by frame_start; offered byte not taken.
      apply_reset(0);
      send_byte(8'h77); send_byte(8'h88);
      pulse_frame_start(1'b1);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
      idle(3);
      check("t5_writes", wr_cnt, 1);

      // Asynchronous reset between bytes 2 and 3 of LED 5.
      pulse_frame_start(1'b0);
      wr_cnt = 0;
      send_n(15);
      send_byte(8'h5A); send_byte(8'hA5);
      check("t6_led_before_reset", led, 5);
      #3;
      reset = 1'b1;
      #1;
      check("t6_async_rgb", rgb, 0);
      check("t6_async_led", led, 0);
      check("t6_async_write", write, 0);
      check("t6_async_ready", ready, 0);
      check("t6_async_overflow", ovf, 0);
      @(negedge clk);
      repeat (2) begin
         check("t6_write_in_reset", write, 0);
         @(negedge clk);
      end
      reset = 1'b0;
      model_clear();
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      idle(4);
      check("t6_writes", wr_cnt, 6);
      check("final_queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
